// File: rtl/comp_seq.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
// Define COMP_EARLY_EXIT_EN to stop on the first differing chunk; otherwise latency is always NCHUNK.
module comp_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       output_comp
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [1:0]       sticky_reg;

    logic [CHUNK-1:0] a_chunk [NCHUNK];
    logic [CHUNK-1:0] b_chunk [NCHUNK];
    logic [CHUNK-1:0] cur_a;
    logic [CHUNK-1:0] cur_b;
    logic             chunk_diff;
    logic [1:0]       chunk_res;
    logic [1:0]       res_next;
    logic             last_chunk;

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
    end

    assign cur_a      = a_chunk[idx_reg];
    assign cur_b      = b_chunk[idx_reg];
    assign chunk_diff = (cur_a != cur_b);
    assign chunk_res  = (cur_a < cur_b) ? 2'd1 : 2'd2;

    // The first recorded difference wins; later chunks are less significant.
    assign res_next = (sticky_reg != 2'd0) ? sticky_reg :
                      (chunk_diff ? chunk_res : 2'd0);

`ifdef COMP_EARLY_EXIT_EN
    assign last_chunk = (idx_reg == '0) || chunk_diff;
`else
    assign last_chunk = (idx_reg == '0);
`endif

    assign in_ready = (state_reg == IDLE) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            idx_reg     <= IDX_MAX;
            sticky_reg  <= 2'd0;
            out_valid   <= 1'b0;
            output_comp <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping the sign bits maps two's-complement order onto unsigned order.
                        a_reg      <= is_signed ? (data_operandA ^ SIGN_MASK) : data_operandA;
                        b_reg      <= is_signed ? (data_operandB ^ SIGN_MASK) : data_operandB;
                        idx_reg    <= IDX_MAX;
                        sticky_reg <= 2'd0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    sticky_reg <= res_next;
                    if (last_chunk) begin
                        output_comp <= res_next;
                        out_valid   <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comp_seq.sv
// Randomised self-checking bench for comp_seq: a cycle-level reference model of the handshake and
// result timing is compared against the DUT on every falling edge, plus directed literal scenarios.
module tb_comp_seq;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef COMP_EARLY_EXIT_EN
    localparam int EE = 1;
`else
    localparam int EE = 0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA = '0;
    logic [WIDTH-1:0] data_operandB = '0;
    logic             is_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       output_comp;

    int n_chk  = 0;
    int n_fail = 0;

    comp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .is_signed    (is_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .output_comp  (output_comp)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] ref_cmp(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic s);
        if (s) begin
            if ($signed(a) < $signed(b)) return 2'd1;
            if ($signed(a) > $signed(b)) return 2'd2;
            return 2'd0;
        end
        if (a < b) return 2'd1;
        if (a > b) return 2'd2;
        return 2'd0;
    endfunction

    function automatic int ref_lat(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
        if (EE == 0) return NCHUNK;
        for (int m = 1; m <= NCHUNK; m++) begin
            if (a[(NCHUNK-m)*CHUNK +: CHUNK] != b[(NCHUNK-m)*CHUNK +: CHUNK]) return m;
        end
        return NCHUNK;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whether an operation is in flight, when its result is due and
    // what output_comp must show; advanced once per falling edge for the coming rising edge.
    bit         m_init = 1'b0;
    bit         m_busy = 1'b0;
    int         now    = 1;
    int         m_due  = 0;
    logic [1:0] m_res  = 2'd0;
    logic [1:0] m_last = 2'd0;

    always @(negedge clock) begin
        bit exp_ov;
        exp_ov = m_busy && (now >= m_due);
        if (m_init) begin
            chk("in_ready", in_ready, !m_busy && !reset);
            chk("out_valid", out_valid, exp_ov);
            chk("output_comp", output_comp, exp_ov ? m_res : m_last);
        end
        if (reset) begin
            m_init = 1'b1;
            m_busy = 1'b0;
            m_last = 2'd0;
        end else if (m_busy && exp_ov && out_ready) begin
            m_busy = 1'b0;
            m_last = m_res;
        end else if (!m_busy && in_valid) begin
            m_busy = 1'b1;
            m_res  = ref_cmp(data_operandA, data_operandB, is_signed);
            m_due  = now + 1 + ref_lat(data_operandA, data_operandB);
        end
        now++;
    end

    // One operation: present it, wait for accept, measure latency (edges after the accept edge)
    // and capture the result, then complete the output handshake.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                          input bit rnd, output int lat, output logic [1:0] res);
        bit got;
        lat = -1;
        res = 2'bxx;
        data_operandA = a;
        data_operandB = b;
        is_signed     = s;
        in_valid      = 1'b1;
        out_ready     = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready never high, required within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        in_valid      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        is_signed     = 1'($urandom);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (out_valid) begin
                lat = k;
                res = output_comp;
                break;
            end
            @(posedge clock);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (lat < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL result_timeout: out_valid never high, required within 40 cycles");
            return;
        end
        for (int j = 0; j < 60 && !out_ready; j++) begin
            @(posedge clock);
            #1;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clock);
        end
        if (!out_ready) out_ready = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic s, input logic [1:0] exp_res, input int exp_lat);
        int lat;
        logic [1:0] res;
        run_op(a, b, s, 1'b0, lat, res);
        $display("op %s a=%08h b=%08h signed=%0d -> comp=%0d latency=%0d", name, a, b, s, res, lat);
        chk({name, "_comp"}, 32'(res), 32'(exp_res));
        chk({name, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int lat;
        logic [1:0] res;
        logic [WIDTH-1:0] a, b;
        logic s;
        int k;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_comp", output_comp, 0);
        @(posedge clock);
        #1;

        directed("u5v3", 32'h0000_0005, 32'h0000_0003, 1'b0, 2'd2, 4);
        directed("u8v1", 32'h8000_0000, 32'h0000_0001, 1'b0, 2'd2, EE ? 1 : 4);
        directed("s8v1", 32'h8000_0000, 32'h0000_0001, 1'b1, 2'd1, EE ? 1 : 4);
        directed("s_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 2'd0, 4);
        directed("u_eq", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2'd0, 4);
        directed("sFv0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2'd1, EE ? 1 : 4);

        // Backpressure: result held while out_ready is low and in_valid pulses.
        data_operandA = 32'h0000_0005;
        data_operandB = 32'h0000_0003;
        is_signed = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (in_ready) break;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            in_valid = (i % 2 == 0);
            data_operandA = $urandom;
            @(negedge clock);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_comp", output_comp, 2);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_hold_last", out_valid, 1);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        $display("op backpressure a=00000005 b=00000003 signed=0 -> comp=%0d", output_comp);

        // Reset in the second RUN cycle discards the operation.
        @(posedge clock);
        #1;
        data_operandA = 32'h1234_5678;
        data_operandB = 32'h1234_5678;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (in_ready) break;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_run_in_ready", in_ready, 1);
        chk("rst_run_out_valid", out_valid, 0);
        chk("rst_run_comp", output_comp, 0);
        $display("op reset_mid_run a=12345678 b=12345678 -> discarded");
        @(posedge clock);
        #1;
        directed("u3v7", 32'h0000_0003, 32'h0000_0007, 1'b0, 2'd1, 4);

        // Random operations with random output backpressure, biased toward long equal prefixes.
        for (int n = 0; n < 3000; n++) begin
            a = $urandom;
            s = 1'($urandom);
            k = $urandom_range(0, NCHUNK - 1);
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (WIDTH'($urandom_range(1, 255)) << (k * CHUNK));
                default: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            run_op(a, b, s, 1'b1, lat, res);
            $display("op rnd%0d a=%08h b=%08h signed=%0d -> comp=%0d latency=%0d", n, a, b, s, res, lat);
            chk("rnd_comp", 32'(res), 32'(ref_cmp(a, b, s)));
            chk("rnd_lat", lat, ref_lat(a, b));
        end

        repeat (3) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
